rf_stream_ctrl: RTL and testbench
=================================

Name: rf_stream_ctrl

Overview:
- Initiator-side controller that drives a 2**SEL-entry register file through its read/write address, write-enable and data ports.
- Accepts fill/dump commands over a valid/ready handshake.
- FILL streams words from an input stream into consecutive register addresses.
- DUMP reads consecutive registers and streams them out.
- Sits between the datapath streams and the register file; it is the only master of the register file's ports.

Parameters:
- SEL, 2, register address width; register file depth is 2**SEL.
- DATA_WIDTH, 16, data word width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  1  0 = FILL, 1 = DUMP.
- cmd_base  in  SEL  first register address.
- cmd_len  in  SEL+1  word count, 0..2**SEL.
- s_data  in  DATA_WIDTH  fill stream data.
- s_valid  in  1  fill data valid.
- s_ready  out  1  fill data accepted.
- m_data  out  DATA_WIDTH  dump stream data.
- m_valid  out  1  dump data valid.
- m_ready  in  1  dump sink ready.
- rf_read_addr  out  SEL  register file read address.
- rf_write_addr  out  SEL  register file write address.
- rf_w_en  out  1  register file write enable.
- rf_in_data  out  DATA_WIDTH  register file write data.
- rf_out_data  in  DATA_WIDTH  register file read data; registered, valid the cycle after rf_read_addr is presented.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset values: all outputs 0 (cmd_ready, s_ready, m_valid, m_data, rf_* outputs, busy, done); FSM in IDLE, address and count registers 0. Reset mid-command abandons it immediately; no further rf_w_en pulses.
- States: IDLE, FILL, RD_ISSUE, RD_CAPT, HOLD, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch op, addr=cmd_base, cnt=cmd_len.
  - cnt=0 goes to DONE (no register access).
  - FILL goes to FILL; DUMP goes to RD_ISSUE.
- FILL:
  - s_ready=1.
  - Each s_valid&s_ready cycle drives rf_w_en=1, rf_write_addr=addr, rf_in_data=s_data combinationally in that same cycle.
  - Then addr+1 (mod 2**SEL, wraps 3 to 0 at SEL=2) and cnt-1.
  - After the last word, go to DONE. Gaps in s_valid stall without writing.
- RD_ISSUE: drive rf_read_addr=addr; go to RD_CAPT.
- RD_CAPT: register m_data<=rf_out_data, set m_valid=1; go to HOLD.
- HOLD:
  - m_data stable while m_valid&!m_ready.
  - On handshake: m_valid falls, addr+1 wraps, cnt-1.
  - Next state is RD_ISSUE, or DONE if cnt reaches 0.
- DONE: done=1 for exactly one cycle; then IDLE. cmd_ready is 0 during DONE.
- rf_w_en is never asserted outside FILL.
- rf_read_addr holds its last value when not issuing.
- Latency: DUMP first m_valid appears 2 cycles after command acceptance; steady-state throughput is 1 word per 3 cycles with m_ready tied high.
- cmd_len > 2**SEL is clamped to 2**SEL.

Optional Feature:
- Macro RF_DUMP_PIPE_EN.
- Defined:
  - DUMP uses a 2-entry output FIFO.
  - A read is issued every cycle while (FIFO occupancy + in-flight reads) < 2 and words remain.
  - With m_ready held high, throughput is 1 word per cycle after 2-cycle initial latency.
  - Order is preserved; DONE is entered only when the FIFO is empty and cnt=0.
- Undefined: non-pipelined FSM exactly as above.

Test Plan:
- Reset, then FILL base=0 len=4 with s_data 0x1111, 0x2222, 0x3333, 0x4444 -> rf_w_en pulses at addrs 0, 1, 2, 3 with those data; done pulses once; busy drops.
- DUMP base=0 len=4 after that fill, m_ready=1 -> m_data 0x1111, 0x2222, 0x3333, 0x4444 in order; first m_valid 2 cycles after accept; with RF_DUMP_PIPE_EN, 4 consecutive valid cycles.
- FILL base=3 len=2 with 0xAAAA, 0xBBBB -> writes addr 3 then addr 0 (wrap); DUMP base=3 len=2 returns 0xAAAA, 0xBBBB.
- DUMP with m_ready low for 5 cycles on the 2nd word -> m_valid stays 1, m_data stable; no word lost or duplicated.
- cmd_len=0 -> done pulses one cycle after accept; rf_w_en never asserted.
- rst asserted mid-FILL after 2 of 4 words -> next cycle all outputs 0, state IDLE; later words on s_data are not written.

Source files
------------

// File: rtl/rf_stream_ctrl.sv
// Register-file stream controller: FILL writes a word stream into consecutive registers, DUMP streams them out.
// Define RF_DUMP_PIPE_EN for the pipelined DUMP path (2-entry output FIFO, one word per cycle).
module rf_stream_ctrl #(
  parameter int unsigned SEL        = 2,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [SEL-1:0]        cmd_base,
  input  logic [SEL:0]          cmd_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [SEL-1:0]        rf_read_addr,
  output logic [SEL-1:0]        rf_write_addr,
  output logic                  rf_w_en,
  output logic [DATA_WIDTH-1:0] rf_in_data,
  input  logic [DATA_WIDTH-1:0] rf_out_data,
  output logic                  busy,
  output logic                  done
);
  localparam int unsigned CW = SEL + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** SEL);

  typedef enum logic [2:0] {IDLE, FILL, RD_ISSUE, RD_CAPT, HOLD, DONE} state_t;

  state_t         state_q, state_d;
  logic [SEL-1:0] addr_q, addr_d, last_rd_q, last_rd_d;
  logic [CW-1:0]  cnt_q, cnt_d, len_c;
  logic           wr_c, issue_c;

`ifdef RF_DUMP_PIPE_EN
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wp_q, rp_q, infl_q, pop_c;
  logic [1:0]            occ_q;
  logic [CW-1:0]         rem_q, rem_d;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = fifo_q[rp_q];
  assign pop_c   = m_valid && m_ready;
  // Keep FIFO entries plus in-flight reads within capacity, counting this cycle's pop
  assign issue_c = !rst && (state_q == RD_ISSUE) && (cnt_q != '0) &&
                   ((3'(occ_q) + 3'(infl_q)) < (3'd2 + 3'(pop_c)));
`else
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign issue_c = !rst && (state_q == RD_ISSUE);
`endif

  // Command length above the register file depth is clamped
  assign len_c = (cmd_len > DEPTH) ? DEPTH : cmd_len;

  // Outputs decoded from state are forced low while reset is asserted
  assign cmd_ready     = !rst && (state_q == IDLE);
  assign busy          = !rst && (state_q != IDLE);
  assign done          = !rst && (state_q == DONE);
  assign s_ready       = !rst && (state_q == FILL);
  assign wr_c          = s_ready && s_valid;
  assign rf_w_en       = wr_c;
  assign rf_write_addr = wr_c ? addr_q : '0;
  assign rf_in_data    = wr_c ? s_data : '0;
  assign rf_read_addr  = issue_c ? addr_q : last_rd_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    last_rd_d = issue_c ? addr_q : last_rd_q;
`ifdef RF_DUMP_PIPE_EN
    rem_d     = rem_q;
`else
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_base;
          cnt_d  = len_c;
`ifdef RF_DUMP_PIPE_EN
          rem_d  = len_c;
`endif
          if (len_c == '0)  state_d = DONE;
          else if (cmd_op)  state_d = RD_ISSUE;
          else              state_d = FILL;
        end
      end
      FILL: begin
        if (wr_c) begin
          addr_d = addr_q + SEL'(1);
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
`ifdef RF_DUMP_PIPE_EN
      RD_ISSUE: begin
        if (issue_c) begin
          addr_d = addr_q + SEL'(1);
          cnt_d  = cnt_q - CW'(1);
        end
        if (pop_c) begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = DONE;
        end
      end
`else
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        m_data_d  = rf_out_data;
        m_valid_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          addr_d    = addr_q + SEL'(1);
          cnt_d     = cnt_q - CW'(1);
          state_d   = (cnt_q == CW'(1)) ? DONE : RD_ISSUE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      last_rd_q <= '0;
`ifdef RF_DUMP_PIPE_EN
      rem_q     <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      occ_q     <= 2'd0;
      infl_q    <= 1'b0;
`else
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
`ifdef RF_DUMP_PIPE_EN
      rem_q     <= rem_d;
      // Read data returns one cycle after issue and is pushed into the FIFO
      infl_q    <= issue_c;
      if (infl_q) begin
        fifo_q[wp_q] <= rf_out_data;
        wp_q         <= ~wp_q;
      end
      if (pop_c) rp_q <= ~rp_q;
      occ_q <= occ_q + 2'(infl_q) - 2'(pop_c);
`else
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_rf_stream_ctrl.sv
// Directed self-checking bench for rf_stream_ctrl with a registered-read register file model.
module tb_rf_stream_ctrl;
`ifdef RF_DUMP_PIPE_EN
  localparam int PER = 1;
`else
  localparam int PER = 3;
`endif

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_op;
  logic [1:0]  cmd_base;
  logic [2:0]  cmd_len;
  logic [15:0] s_data, m_data, rf_in_data, rf_out_data;
  logic        s_valid, s_ready, m_valid, m_ready, rf_w_en, busy, done;
  logic [1:0]  rf_read_addr, rf_write_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem    [4];
  logic [15:0] fill_w [4];
  logic [15:0] exp_w  [4];

  rf_stream_ctrl #(.SEL(2), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .rf_read_addr(rf_read_addr),
    .rf_write_addr(rf_write_addr), .rf_w_en(rf_w_en), .rf_in_data(rf_in_data),
    .rf_out_data(rf_out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, registered read
  always @(posedge clk) begin
    if (rf_w_en) mem[rf_write_addr] <= rf_in_data;
    rf_out_data <= mem[rf_read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_s_ready"},   32'(s_ready),   32'd0);
    chk({tag, "_m_valid"},   32'(m_valid),   32'd0);
    chk({tag, "_m_data"},    32'(m_data),    32'd0);
    chk({tag, "_rf_w_en"},   32'(rf_w_en),   32'd0);
    chk({tag, "_rd_addr"},   32'(rf_read_addr),  32'd0);
    chk({tag, "_wr_addr"},   32'(rf_write_addr), 32'd0);
    chk({tag, "_in_data"},   32'(rf_in_data),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
  endtask

  task automatic do_fill(input logic [1:0] base, input logic [2:0] len, input int n, input int gap);
    logic [1:0] a;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = base; cmd_len = len;
    #1;
    chk("fill_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap) begin
        s_valid = 1'b0;
        #1;
        chk("fill_gap_we", 32'(rf_w_en), 32'd0);
        chk("fill_gap_busy", 32'(busy), 32'd1);
        tick();
      end
      s_valid = 1'b1; s_data = fill_w[i];
      #1;
      a = base + 2'(i);
      chk("fill_we", 32'(rf_w_en), 32'd1);
      chk("fill_addr", 32'(rf_write_addr), 32'(a));
      chk("fill_data", 32'(rf_in_data), 32'(fill_w[i]));
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("fill_done", 32'(done), 32'd1);
    chk("fill_done_we", 32'(rf_w_en), 32'd0);
    chk("fill_done_ready", 32'(cmd_ready), 32'd0);
    tick();
    #1;
    chk("fill_done_clr", 32'(done), 32'd0);
    chk("fill_idle_busy", 32'(busy), 32'd0);
    chk("fill_idle_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_dump(input logic [1:0] base, input logic [2:0] len, input int stall_word,
                         input int stall_n);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = base; cmd_len = len; m_ready = 1'b1;
    #1;
    chk("dump_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    while (got < int'(len) && cyc < 200) begin
      m_ready = 1'b1;
      #1;
      if (m_valid && got == stall_word && stall_n > 0 && !stalled) begin
        m_ready = 1'b0;
        stalled = 1'b1;
        for (int k = 0; k < stall_n; k++) begin
          #1;
          chk("stall_valid", 32'(m_valid), 32'd1);
          chk("stall_data", 32'(m_data), 32'(exp_w[got]));
          tick();
          cyc++;
        end
        m_ready = 1'b1;
        #1;
      end
      if (m_valid) begin
        chk("dump_data", 32'(m_data), 32'(exp_w[got]));
        if (stall_n == 0) chk("dump_cycle", 32'(cyc), 32'(2 + PER * got));
        got++;
      end
      tick();
      cyc++;
    end
    chk("dump_words", 32'(got), 32'(len));
    #1;
    chk("dump_done", 32'(done), 32'd1);
    chk("dump_valid_low", 32'(m_valid), 32'd0);
    tick();
    #1;
    chk("dump_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = 2'd0; cmd_len = 3'd0;
    s_data = 16'h0; s_valid = 1'b0; m_ready = 1'b1;
    tick();
    tick();
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);

    fill_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_fill(2'd0, 3'd4, 4, 2);
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_dump(2'd0, 3'd4, -1, 0);

    fill_w = '{16'hAAAA, 16'hBBBB, 16'h0, 16'h0};
    do_fill(2'd3, 3'd2, 2, -1);
    exp_w = '{16'hAAAA, 16'hBBBB, 16'h0, 16'h0};
    do_dump(2'd3, 3'd2, -1, 0);

    exp_w = '{16'hBBBB, 16'h2222, 16'h3333, 16'hAAAA};
    do_dump(2'd0, 3'd4, 1, 5);

    // Zero-length command: done one cycle after accept, no write
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 2'd2; cmd_len = 3'd0;
    #1;
    chk("zero_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0; s_valid = 1'b1; s_data = 16'hDEAD;
    #1;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_we", 32'(rf_w_en), 32'd0);
    chk("zero_s_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = 1'b0;
    #1;
    chk("zero_done_clr", 32'(done), 32'd0);
    chk("zero_mem", 32'(mem[2]), 32'h3333);

    // Oversized length clamps to four words, wrapping from address 1
    fill_w = '{16'h5001, 16'h5002, 16'h5003, 16'h5004};
    do_fill(2'd1, 3'd5, 4, -1);
    chk("clamp_mem0", 32'(mem[0]), 32'h5004);

    // Reset in the middle of a fill
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 2'd0; cmd_len = 3'd4;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 16'hC001 + 16'(i);
      #1;
      chk("rfill_we", 32'(rf_w_en), 32'd1);
      tick();
    end
    rst = 1'b1; s_data = 16'hC003;
    #1;
    chk("rst_we_gated", 32'(rf_w_en), 32'd0);
    tick();
    #1;
    chk_all_zero("mid_reset");
    rst = 1'b0; s_data = 16'hC004;
    #1;
    chk("after_rst_s_ready", 32'(s_ready), 32'd0);
    chk("after_rst_we", 32'(rf_w_en), 32'd0);
    chk("after_rst_ready", 32'(cmd_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    #1;
    chk("rst_mem0", 32'(mem[0]), 32'hC001);
    chk("rst_mem1", 32'(mem[1]), 32'hC002);
    chk("rst_mem2", 32'(mem[2]), 32'h5002);
    chk("rst_mem3", 32'(mem[3]), 32'h5003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
